udp_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single `udp_send` header/payload path between up to NUM_REQ payload sources (IQ stream, wideband, discovery/config replies). It sits between the source FIFOs and `udp_send`. Per packet it grants one requester and latches that requester's length, port ID and destination port. It then paces payload bytes out of the requester's FIFO into `tx_data`/`tx_enable`, and enforces an idle gap before the next packet.

---
 rtl/udp_tx_arbiter_pkg.sv | 15 +
 rtl/udp_tx_arbiter_if.sv | 38 +++
 rtl/udp_tx_arbiter_rr_pick.sv | 34 +++
 rtl/udp_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_tx_arbiter_pkg.sv
// Shared definitions for the UDP transmit arbiter: FSM state encoding and
// default sizing parameters.
package udp_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_NUM_REQ    = 3;
  localparam int unsigned DEFAULT_GAP_CYCLES = 12;

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// Bundle of request, payload and udp_send-facing signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic
// (source FIFOs, udp_send).
interface udp_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = udp_tx_pkg::DEFAULT_NUM_REQ
);

  logic                    mac_ready;
  logic                    udp_active;
  logic [NUM_REQ-1:0]      req;
  logic [16*NUM_REQ-1:0]   req_length;
  logic [8*NUM_REQ-1:0]    req_port_id;
  logic [16*NUM_REQ-1:0]   req_dst_port;
  logic [8*NUM_REQ-1:0]    req_data;
  logic [NUM_REQ-1:0]      ack;
  logic [NUM_REQ-1:0]      rd_en;
  logic [NUM_REQ-1:0]      grant;
  logic                    tx_enable;
  logic [7:0]              tx_data;
  logic [15:0]             tx_length;
  logic [7:0]              tx_port_id;
  logic [15:0]             tx_dst_port;
  logic                    busy;
  logic                    err_zero_len;

  modport slave (
    input  mac_ready, udp_active, req, req_length, req_port_id, req_dst_port, req_data,
    output ack, rd_en, grant, tx_enable, tx_data, tx_length, tx_port_id, tx_dst_port,
           busy, err_zero_len
  );

  modport master (
    output mac_ready, udp_active, req, req_length, req_port_id, req_dst_port, req_data,
    input  ack, rd_en, grant, tx_enable, tx_data, tx_length, tx_port_id, tx_dst_port,
           busy, err_zero_len
  );

endinterface

// File: rtl/udp_tx_arbiter_rr_pick.sv
// Combinational round-robin select: first requesting index strictly after
// `last`, wrapping around. Returns one-hot, binary index and a valid flag.
module rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          valid
);

  int unsigned pos;

  // Walk the candidates in priority order starting just after last.
  always_comb begin
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    pos    = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = (32'(last) + k) % N;
      for (int unsigned i = 0; i < N; i++) begin
        if (!valid && (i == pos) && req[i]) begin
          valid     = 1'b1;
          onehot[i] = 1'b1;
          index     = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin scheduler sharing the udp_send path between NUM_REQ payload
// sources: grants one source per packet, latches its header fields, paces
// its FIFO bytes onto tx_data/tx_enable and enforces an idle gap afterwards.
module udp_tx_arbiter
  import udp_tx_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic            clock,
  input  logic            reset,
  udp_tx_arbiter_if.slave bus
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t              state;
  logic [IW-1:0]       last;
  logic [IW-1:0]       gidx;
  logic [15:0]         remaining;
  logic [GW-1:0]       gap_cnt;
  logic                en_d1;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IW-1:0]       pick_index;
  logic                pick_valid;
  logic [15:0]         sel_length;
  logic [7:0]          sel_port_id;
  logic [15:0]         sel_dst_port;
  logic [7:0]          sel_data;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req    (bus.req),
    .last   (last),
    .onehot (pick_onehot),
    .index  (pick_index),
    .valid  (pick_valid)
  );

  // Header fields of the source about to be granted, and payload byte of the owner.
  always_comb begin
    sel_length   = '0;
    sel_port_id  = '0;
    sel_dst_port = '0;
    sel_data     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_index == IW'(k)) begin
        sel_length   = bus.req_length[k*16 +: 16];
        sel_port_id  = bus.req_port_id[k*8 +: 8];
        sel_dst_port = bus.req_dst_port[k*16 +: 16];
      end
      if (gidx == IW'(k)) begin
        sel_data = bus.req_data[k*8 +: 8];
      end
    end
  end

  // Packet FSM: arbitration, header latch, read pacing, drain wait and gap count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      last             <= IW'(NUM_REQ - 1);
      gidx             <= '0;
      remaining        <= '0;
      gap_cnt          <= '0;
      bus.ack          <= '0;
      bus.rd_en        <= '0;
      bus.grant        <= '0;
      bus.tx_length    <= '0;
      bus.tx_port_id   <= '0;
      bus.tx_dst_port  <= '0;
      bus.busy         <= 1'b0;
      bus.err_zero_len <= 1'b0;
    end else begin
      bus.ack          <= '0;
      bus.err_zero_len <= 1'b0;
      bus.rd_en        <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.mac_ready && pick_valid) begin
            bus.tx_length   <= sel_length;
            bus.tx_port_id  <= sel_port_id;
            bus.tx_dst_port <= sel_dst_port;
            bus.ack         <= pick_onehot;
            bus.busy        <= 1'b1;
            last            <= pick_index;
            gidx            <= pick_index;
            remaining       <= sel_length;
            if (sel_length == '0) begin
              bus.err_zero_len <= 1'b1;
              bus.grant        <= '0;
              gap_cnt          <= '0;
              state            <= ST_GAP;
            end else begin
              bus.grant <= pick_onehot;
              state     <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (remaining != '0) begin
            bus.rd_en <= bus.grant;
            remaining <= remaining - 16'd1;
          end else if ((bus.rd_en == '0) && !en_d1 && !bus.tx_enable) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!bus.udp_active) begin
            bus.grant <= '0;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Two-stage strobe pipeline; the data byte arrives one clock after rd_en.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_d1         <= 1'b0;
      bus.tx_enable <= 1'b0;
      bus.tx_data   <= '0;
    end else begin
      en_d1         <= |bus.rd_en;
      bus.tx_enable <= en_d1;
      if (en_d1) begin
        bus.tx_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: stimulus pushes expected packets in
// round-robin order; a monitor pops and checks each grant and its payload.
module tb_udp_tx_arbiter;

  localparam int unsigned N = 3;
  localparam int unsigned G = 12;

  typedef struct {
    int unsigned src;
    int unsigned len;
    logic [7:0]  port;
    logic [15:0] dst;
  } exp_t;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  udp_tx_arbiter_if #(.NUM_REQ(N)) bus();

  udp_tx_arbiter #(
    .NUM_REQ    (N),
    .GAP_CYCLES (G)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned cyc        = 0;

  exp_t        exp_q[$];
  exp_t        pend [N];
  logic [7:0]  fifo_q [N][$];
  logic [7:0]  expb_q [N][$];
  int unsigned mlast = N - 1;
  int unsigned launch_cyc;

  // monitor state
  bit          in_pkt = 0;
  exp_t        cur;
  int unsigned rd_cnt, te_cnt, payload_errs;
  bit          bad_rd;
  int unsigned ack_cnt = 0;
  int unsigned last_ack_cyc, first_rd_cyc, first_te_cyc;
  bit          zl_seen = 0;
  int unsigned zl_cyc = 0;
  int unsigned stray = 0;

  // udp_send model state
  bit          fall_seen = 0;
  int unsigned fall_cyc = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    compared++;
    if (act !== req_v) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  function automatic logic [N-1:0] oh(input int unsigned s);
    logic [N-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] outs_now();
    return {4'h0, bus.ack, bus.rd_en, bus.grant, bus.tx_enable, bus.tx_data, bus.tx_length,
            bus.tx_port_id, bus.tx_dst_port, bus.busy, bus.err_zero_len};
  endfunction

  // Source FIFO model: data appears one clock after the sampled read strobe.
  initial begin
    logic [N-1:0] rd_s;
    bus.req_data = '0;
    forever begin
      @(negedge clock);
      rd_s = reset ? '0 : bus.rd_en;
      @(posedge clock);
      #1;
      for (int unsigned i = 0; i < N; i++) begin
        if (rd_s[i] && fifo_q[i].size() > 0) bus.req_data[i*8 +: 8] = fifo_q[i].pop_front();
      end
    end
  end

  // udp_send model: active from grant until a random delay after tx_enable ends.
  initial begin
    int  cd;
    bit  prev_te;
    cd = -1;
    prev_te = 1'b0;
    bus.udp_active = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        bus.udp_active = 1'b0;
        cd = -1;
        prev_te = 1'b0;
        fall_seen = 0;
      end else begin
        if (bus.ack != '0 && bus.tx_length != '0) bus.udp_active = 1'b1;
        if (prev_te && !bus.tx_enable) cd = int'($urandom_range(0, 4));
        else if (cd > 0) cd--;
        if (cd == 0) begin
          bus.udp_active = 1'b0;
          fall_cyc = cyc;
          fall_seen = 1;
          cd = -1;
        end
        prev_te = bus.tx_enable;
      end
    end
  end

  // Monitor: pop expected packet on each ack, then follow its strobes and bytes.
  initial begin
    int unsigned rel;
    logic [7:0]  b;
    forever begin
      @(negedge clock);
      if (reset) begin
        in_pkt  = 0;
        zl_seen = 0;
      end else if (bus.ack != '0) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 64'(bus.ack), 64'(0));
        end else begin
          cur = exp_q.pop_front();
          check("ack_owner", 64'(bus.ack), 64'(oh(cur.src)));
          check("tx_length", 64'(bus.tx_length), 64'(cur.len));
          check("tx_port_id", 64'(bus.tx_port_id), 64'(cur.port));
          check("tx_dst_port", 64'(bus.tx_dst_port), 64'(cur.dst));
          check("err_zero_len", 64'(bus.err_zero_len), 64'(cur.len == 0));
          if (zl_seen || fall_seen) begin
            rel = (zl_seen && (!fall_seen || zl_cyc > fall_cyc)) ? zl_cyc : fall_cyc;
            check("gap_respected", 64'((cyc - rel) >= G + 1), 64'(1));
          end
          last_ack_cyc = cyc;
          if (cur.len == 0) begin
            check("zero_len_grant", 64'(bus.grant), 64'(0));
            zl_cyc  = cyc;
            zl_seen = 1;
          end else begin
            check("grant", 64'(bus.grant), 64'(oh(cur.src)));
            in_pkt = 1;
            rd_cnt = 0;
            te_cnt = 0;
            payload_errs = 0;
            bad_rd = 0;
          end
        end
      end else if (in_pkt) begin
        if (bus.rd_en != '0) begin
          if (bus.rd_en == oh(cur.src)) begin
            if (rd_cnt == 0) first_rd_cyc = cyc;
            rd_cnt++;
          end else begin
            bad_rd = 1;
          end
        end
        if (bus.tx_enable) begin
          if (te_cnt == 0) first_te_cyc = cyc;
          if (expb_q[cur.src].size() == 0) begin
            payload_errs++;
          end else begin
            b = expb_q[cur.src].pop_front();
            if (bus.tx_data !== b) begin
              if (payload_errs == 0)
                $display("first bad byte %0d: got 0x%0h wanted 0x%0h", te_cnt, bus.tx_data, b);
              payload_errs++;
            end
          end
          te_cnt++;
        end
        if (bus.grant == '0) begin
          check("rd_en_count", 64'(rd_cnt), 64'(cur.len));
          check("tx_enable_count", 64'(te_cnt), 64'(cur.len));
          check("payload_errors", 64'(payload_errs), 64'(0));
          check("rd_en_foreign", 64'(bad_rd), 64'(0));
          in_pkt = 0;
        end
      end else if (bus.rd_en != '0 || bus.tx_enable) begin
        stray++;
      end
    end
  end

  task automatic issue(input int unsigned s, input int unsigned len,
                       input logic [7:0] port, input logic [15:0] dst);
    logic [7:0] v;
    bus.req_length[s*16 +: 16]  = len[15:0];
    bus.req_port_id[s*8 +: 8]   = port;
    bus.req_dst_port[s*16 +: 16] = dst;
    for (int unsigned i = 0; i < len; i++) begin
      v = 8'($urandom);
      fifo_q[s].push_back(v);
      expb_q[s].push_back(v);
    end
    pend[s] = '{src: s, len: len, port: port, dst: dst};
  endtask

  // Raise a set of requests together; grants follow cyclic order after the model's last.
  task automatic launch(input logic [N-1:0] m);
    int unsigned base, idx;
    base = mlast;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (base + k) % N;
      if (m[idx]) begin
        exp_q.push_back(pend[idx]);
        mlast = idx;
      end
    end
    launch_cyc = cyc;
    bus.req = m;
  endtask

  task automatic serve(input int unsigned budget, input bit rnd_mac);
    int unsigned n;
    bit to;
    n  = 0;
    to = 0;
    forever begin
      @(negedge clock);
      if (bus.ack != '0) bus.req = bus.req & ~bus.ack;
      if (rnd_mac) bus.mac_ready = ($urandom_range(0, 3) != 0);
      if (bus.req == '0 && !bus.busy && exp_q.size() == 0 && !in_pkt) break;
      n++;
      if (n >= budget) begin
        to = 1;
        break;
      end
    end
    bus.mac_ready = 1'b1;
    check("serve_timeout", 64'(to), 64'(0));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a0, j, n;
    logic [N-1:0] m;
    reset = 1'b0;
    bus.mac_ready = 1'b0;
    bus.req = '0;
    bus.req_length = '0;
    bus.req_port_id = '0;
    bus.req_dst_port = '0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_outputs", outs_now(), 64'(0));
    reset = 1'b0;
    bus.mac_ready = 1'b1;
    repeat (2) @(negedge clock);

    // single request with fixed header and latency checks
    issue(1, 5, 8'd3, 16'd1024);
    @(posedge clock); #1;
    launch(3'b010);
    serve(500, 0);
    check("ack_latency", 64'(last_ack_cyc - launch_cyc), 64'(1));
    check("rd_en_latency", 64'(first_rd_cyc - launch_cyc), 64'(2));
    check("tx_enable_latency", 64'(first_te_cyc - launch_cyc), 64'(4));

    // all sources requesting, L=4, two rounds
    for (int r = 0; r < 2; r++) begin
      for (int unsigned s = 0; s < N; s++) issue(s, 4, 8'(s + 8), 16'(5000 + s));
      @(posedge clock); #1;
      launch(3'b111);
      serve(1000, 0);
    end

    // zero-length request on source 2 alongside source 0
    issue(2, 0, 8'h22, 16'h2200);
    issue(0, 3, 8'h00, 16'h0100);
    @(posedge clock); #1;
    launch(3'b101);
    serve(1000, 0);

    // mac_ready low holds off arbitration
    bus.mac_ready = 1'b0;
    issue(0, 2, 8'h44, 16'h4400);
    @(posedge clock); #1;
    a0 = ack_cnt;
    launch(3'b001);
    repeat (20) @(negedge clock);
    check("no_ack_mac_not_ready", 64'(ack_cnt - a0), 64'(0));
    check("idle_mac_not_ready", 64'(bus.busy), 64'(0));
    @(posedge clock); #1;
    j = cyc;
    bus.mac_ready = 1'b1;
    serve(500, 0);
    check("mac_ready_ack_latency", 64'(last_ack_cyc - j), 64'(1));

    // randomized phases
    for (int p = 0; p < 12; p++) begin
      m = N'($urandom_range(1, 7));
      for (int unsigned s = 0; s < N; s++)
        if (m[s]) issue(s, ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12),
                        8'($urandom), 16'($urandom));
      @(posedge clock); #1;
      launch(m);
      serve(2000, 1);
    end

    // reset at the third payload byte of an L=10 packet
    issue(1, 10, 8'h11, 16'h2222);
    @(posedge clock); #1;
    launch(3'b010);
    n = 0;
    for (int unsigned t = 0; t < 200 && n < 3; t++) begin
      @(negedge clock);
      if (bus.ack != '0) bus.req = bus.req & ~bus.ack;
      if (bus.tx_enable) n++;
    end
    check("reached_third_byte", 64'(n), 64'(3));
    reset = 1'b1;
    #1;
    check("reset_mid_packet_outputs", outs_now(), 64'(0));
    repeat (2) @(negedge clock);
    check("reset_hold_outputs", outs_now(), 64'(0));
    for (int unsigned s = 0; s < N; s++) begin
      fifo_q[s].delete();
      expb_q[s].delete();
    end
    exp_q.delete();
    bus.req = '0;
    mlast = N - 1;
    @(negedge clock);
    reset = 1'b0;
    for (int unsigned s = 0; s < N; s++) issue(s, $urandom_range(1, 6), 8'(s + 40), 16'(900 + s));
    @(posedge clock); #1;
    launch(3'b111);
    serve(1000, 0);

    // maximum length packet
    issue(2, 65535, 8'h7e, 16'hffff);
    @(posedge clock); #1;
    launch(3'b100);
    serve(70000, 0);
    check("idle_after_max_len", 64'(bus.busy), 64'(0));

    check("stray_strobes", 64'(stray), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
